// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, FSM state encoding and the byte-wide CRC-32 step.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_DRAIN,
    ST_IFG
  } state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  // Reflected (LSB-first) CRC-32 update over one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_framer_if.sv
// Payload byte stream (valid/ready handshake with end-of-frame marker).
interface gmii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, output s_valid, output s_last, input  s_ready);
  modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register: init has priority over en; crc is the raw register.
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII TX framer: preamble/SFD insertion, min-length padding, CRC-32 FCS append,
// underrun abort with drain, and inter-frame gap enforcement.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic             gmii_tx_clk,
  input  logic             reset_n,
  gmii_tx_framer_if.slave  s,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic             frame_sent,
  output logic             underrun
);

  localparam int unsigned   IFG_W       = $clog2(IFG_BYTES + 2);
  localparam logic [10:0]   PRE_LAST    = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0]   MIN_CNT     = 11'(MIN_FRAME);
  localparam logic [IFG_W-1:0] IFG_LOAD    = IFG_W'(IFG_BYTES);
  localparam logic [IFG_W-1:0] IFG_LOAD_ER = IFG_W'(IFG_BYTES + 1);
  localparam logic [IFG_W-1:0] IFG_ONE     = IFG_W'(1);

  state_t           state_q, state_d;
  logic [10:0]      byte_cnt_q, byte_cnt_d;
  logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
  logic [2:0]       fcs_idx_q, fcs_idx_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic             frame_sent_q, frame_sent_d;
  logic             underrun_q, underrun_d;

  logic             crc_init, crc_en;
  logic [7:0]       crc_data;
  logic [31:0]      crc;
  logic [31:0]      fcs_word;
  logic [10:0]      byte_cnt_inc;
  logic             start;

  eth_crc32 u_crc (
    .clk   (gmii_tx_clk),
    .rst_n (reset_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (crc_data),
    .crc   (crc)
  );

  assign fcs_word     = ~crc;
  assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign s.s_ready    = (state_q == ST_DATA) || (state_q == ST_DRAIN);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    fcs_idx_d    = fcs_idx_q;
    txd_d        = '0;
    tx_en_d      = 1'b0;
    tx_er_d      = 1'b0;
    frame_sent_d = 1'b0;
    underrun_d   = 1'b0;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    crc_data     = s.s_data;
    start        = 1'b0;

    unique case (state_q)
      ST_IDLE: start = s.s_valid;
      ST_PRE: begin
        txd_d   = PREAMBLE_BYTE;
        tx_en_d = 1'b1;
        if (byte_cnt_q == PRE_LAST) state_d = ST_SFD;
        else                        byte_cnt_d = byte_cnt_inc;
      end
      ST_SFD: begin
        txd_d      = SFD_BYTE;
        tx_en_d    = 1'b1;
        byte_cnt_d = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (s.s_valid) begin
          txd_d      = s.s_data;
          crc_en     = 1'b1;
          byte_cnt_d = byte_cnt_inc;
          if (s.s_last) begin
            fcs_idx_d = '0;
            state_d   = (byte_cnt_inc < MIN_CNT) ? ST_PAD : ST_FCS;
          end
        end else begin
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          // With s_last already asserted there is nothing to drain; the extra
          // IFG count covers the error byte still on the wire.
          if (s.s_last) begin
            ifg_cnt_d = IFG_LOAD_ER;
            state_d   = ST_IFG;
          end else begin
            state_d   = ST_DRAIN;
          end
        end
      end
      ST_PAD: begin
        tx_en_d    = 1'b1;
        crc_en     = 1'b1;
        crc_data   = '0;
        byte_cnt_d = byte_cnt_inc;
        if (byte_cnt_inc >= MIN_CNT) begin
          fcs_idx_d = '0;
          state_d   = ST_FCS;
        end
      end
      ST_FCS: begin
        if (fcs_idx_q == 3'd4) begin
          frame_sent_d = 1'b1;
          ifg_cnt_d    = IFG_LOAD;
          state_d      = ST_IFG;
        end else begin
          txd_d     = fcs_word[{fcs_idx_q[1:0], 3'b000} +: 8];
          tx_en_d   = 1'b1;
          fcs_idx_d = fcs_idx_q + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (s.s_valid && s.s_last) begin
          ifg_cnt_d = IFG_LOAD;
          state_d   = ST_IFG;
        end
      end
      ST_IFG: begin
        // The edge at which the counter expires may already start a frame.
        if (ifg_cnt_q <= IFG_ONE) begin
          ifg_cnt_d = '0;
          state_d   = ST_IDLE;
          start     = s.s_valid;
        end else begin
          ifg_cnt_d = ifg_cnt_q - IFG_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d    = ST_PRE;
      byte_cnt_d = 11'd1;
      txd_d      = PREAMBLE_BYTE;
      tx_en_d    = 1'b1;
      crc_init   = 1'b1;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= '0;
      ifg_cnt_q    <= '0;
      fcs_idx_q    <= '0;
      txd_q        <= '0;
      tx_en_q      <= 1'b0;
      tx_er_q      <= 1'b0;
      frame_sent_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ifg_cnt_q    <= ifg_cnt_d;
      fcs_idx_q    <= fcs_idx_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      tx_er_q      <= tx_er_d;
      frame_sent_q <= frame_sent_d;
      underrun_q   <= underrun_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;
  assign frame_sent = frame_sent_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: frame format, padding, FCS, IFG, underrun, reset.
module tb_gmii_tx_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  gmii_tx_framer_if sif ();
  logic [7:0] txd;
  logic       tx_en, tx_er, frame_sent, underrun;

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12)) dut (
    .gmii_tx_clk (clk),
    .reset_n     (rst_n),
    .s           (sif),
    .gmii_txd    (txd),
    .gmii_tx_en  (tx_en),
    .gmii_tx_er  (tx_er),
    .frame_sent  (frame_sent),
    .underrun    (underrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int k = 0; k < 8; k++) begin
      fb = r[0] ^ b[k];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  logic [7:0] payload [0:2047];

  // Wire-side monitor: capture each tx_en burst, count pulses, measure idle gaps.
  logic [7:0] cap [0:2199];
  logic [7:0] frm [0:2199];
  int cap_len = 0, frm_len = 0, cur_er = 0, frm_er = 0;
  int frames_done = 0, sent_cnt = 0, urun_cnt = 0, both_cnt = 0, er_total = 0;
  int idle_cnt = 1000, last_gap = 0, accepted = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (frame_sent) sent_cnt++;
    if (underrun) urun_cnt++;
    if (frame_sent && underrun) both_cnt++;
    if (tx_er) er_total++;
    if (sif.s_valid && sif.s_ready) accepted++;
    if (tx_en) begin
      if (!prev_en) begin
        last_gap = idle_cnt;
        cap_len  = 0;
        cur_er   = 0;
      end
      if (cap_len < 2200) cap[cap_len] = txd;
      cap_len++;
      if (tx_er) cur_er++;
    end else begin
      if (prev_en) begin
        for (int i = 0; i < cap_len && i < 2200; i++) frm[i] = cap[i];
        frm_len = cap_len;
        frm_er  = cur_er;
        frames_done++;
        idle_cnt = 0;
      end
      idle_cnt++;
    end
    prev_en = tx_en;
  end

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send(input int len, input int drop_at, input int drop_cyc);
    int i = 0;
    int guard = 0;
    logic rdy;
    sif.s_valid = 1'b1;
    sif.s_data  = payload[0];
    sif.s_last  = (len == 1);
    while (i < len) begin
      @(negedge clk);
      rdy = sif.s_ready && sif.s_valid;
      @(posedge clk);
      #1;
      if (rdy) begin
        i++;
        if (i < len) begin
          sif.s_data = payload[i];
          sif.s_last = (i == len - 1);
        end
        if (i == drop_at) begin
          sif.s_valid = 1'b0;
          repeat (drop_cyc) @(posedge clk);
          #1 sif.s_valid = 1'b1;
        end
      end
      guard++;
      if (guard > 5000) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("frame_done", (frames_done >= target) ? 32'd1 : 32'd0, 32'd1);
    #1;
  endtask

  task automatic verify(input string tag, input int len);
    int dlen, exp_len, bad, b;
    logic [31:0] c;
    logic [7:0] e;
    dlen    = (len < 60) ? 60 : len;
    exp_len = 8 + dlen + 4;
    check({tag, "_len"}, frm_len, exp_len);
    check({tag, "_er"}, frm_er, 0);
    if (frm_len == exp_len) begin
      bad = 0;
      for (int i = 0; i < 7; i++) if (frm[i] !== 8'h55) bad++;
      if (frm[7] !== 8'hD5) bad++;
      check({tag, "_preamble"}, bad, 0);
      bad = 0;
      c   = 32'hFFFF_FFFF;
      for (int i = 0; i < dlen; i++) begin
        e = (i < len) ? payload[i] : 8'h00;
        if (frm[8+i] !== e) bad++;
        c = crc_step(c, e);
      end
      check({tag, "_data"}, bad, 0);
      b = 8 + dlen;
      check({tag, "_fcs"}, {frm[b+3], frm[b+2], frm[b+1], frm[b]}, ~c);
    end
  endtask

  initial begin
    int base, s0, u0, a0, er0, guard;
    int lens [7];

    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", txd, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_er", tx_er, 0);
    check("rst_s_ready", sif.s_ready, 0);
    check("rst_pulses", {frame_sent, underrun}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single-byte frame padded to minimum
    payload[0] = 8'hAB;
    base = frames_done; s0 = sent_cnt;
    send(1, -1, 0);
    wait_frames(base + 1, 300);
    verify("t1", 1);
    check("t1_sent", sent_cnt - s0, 1);

    // 2: 64-byte frame, no padding
    for (int i = 0; i < 64; i++) payload[i] = 8'(i);
    base = frames_done;
    send(64, -1, 0);
    wait_frames(base + 1, 300);
    verify("t2", 64);

    // 3: back-to-back frames, s_valid held high
    for (int i = 0; i < 20; i++) payload[i] = 8'(i * 3 + 1);
    base = frames_done; s0 = sent_cnt;
    send(20, -1, 0);
    send(20, -1, 0);
    wait_frames(base + 2, 300);
    check("t3_gap", last_gap, 12);
    verify("t3", 20);
    check("t3_sent", sent_cnt - s0, 2);

    // 4: underrun after 10 bytes, 5 more beats drained
    for (int i = 0; i < 15; i++) payload[i] = 8'(8'h80 + i);
    base = frames_done; s0 = sent_cnt; u0 = urun_cnt; a0 = accepted;
    send(15, 10, 3);
    wait_frames(base + 1, 300);
    repeat (30) @(posedge clk);
    #1;
    check("t4_len", frm_len, 19);
    check("t4_er", frm_er, 1);
    check("t4_last_byte", frm[18], 8'h00);
    check("t4_underrun", urun_cnt - u0, 1);
    check("t4_sent", sent_cnt - s0, 0);
    check("t4_accepted", accepted - a0, 15);

    // 5: reset during FCS, then immediate restart
    for (int i = 0; i < 64; i++) payload[i] = 8'(i) ^ 8'h5A;
    send(64, -1, 0);
    guard = 0;
    while (!(tx_en && cap_len >= 73) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("t5_reach_fcs", (guard < 200) ? 32'd1 : 32'd0, 32'd1);
    s0 = sent_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_en", tx_en, 0);
    check("t5_async_txd", txd, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = frames_done;
    payload[0]  = 8'h3C;
    sif.s_data  = 8'h3C;
    sif.s_last  = 1'b1;
    sif.s_valid = 1'b1;
    @(negedge clk);
    check("t5_before_edge", tx_en, 0);
    @(negedge clk);
    check("t5_first_en", tx_en, 1);
    check("t5_first_txd", txd, 8'h55);
    @(posedge clk);
    #1;
    send(1, -1, 0);
    wait_frames(base + 1, 300);
    verify("t5", 1);
    check("t5_sent", sent_cnt - s0, 1);

    // 6: pad boundaries and random payloads with random idle before start
    er0 = er_total;
    lens[0] = 59; lens[1] = 60; lens[2] = 61;
    for (int f = 3; f < 7; f++) lens[f] = int'($urandom_range(1, 1514));
    for (int f = 0; f < 7; f++) begin
      for (int i = 0; i < lens[f]; i++) payload[i] = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
      base = frames_done;
      send(lens[f], -1, 0);
      wait_frames(base + 1, 300);
      verify($sformatf("t6_%0d", f), lens[f]);
    end
    check("t6_no_er", er_total - er0, 0);
    check("pulses_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
